// File: rtl/spram_fifo_pkg.sv
// Shared types and helpers for the single-port-RAM FWFT FIFO.
package spram_fifo_pkg;

    // Operation issued to the single-port RAM in a given cycle.
    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_RD   = 2'd1,
        RAM_WR   = 2'd2
    } ram_op_e;

    // Number of prefetch (skid) buffer entries in front of the consumer.
    localparam int OUT_DEPTH = 2;

    // Occupancy counter width: must hold RAM words plus the prefetch buffer.
    function automatic int calc_cnt_width(input int depth);
        return $clog2(depth + OUT_DEPTH + 1);
    endfunction

endpackage

// File: rtl/spram_fifo_if.sv
// Producer/consumer handshake bundle for spram_fifo_fwft.
interface spram_fifo_if
    import spram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = calc_cnt_width(32)
);
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [CNT_WIDTH-1:0]  count;
    logic                  almost_full;
    logic                  almost_empty;

    // Environment side: produces writes, consumes reads.
    modport master (
        output wvalid, wdata, rready,
        input  wready, rvalid, rdata, count, almost_full, almost_empty
    );

    // FIFO side.
    modport slave (
        input  wvalid, wdata, rready,
        output wready, rvalid, rdata, count, almost_full, almost_empty
    );
endinterface

// File: rtl/spram_1rw.sv
// Behavioural single-port synchronous RAM, one access per cycle, read
// data valid one cycle after the read. Replaced by the macro at synthesis.
module spram_1rw
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          en,
    input  logic                          we,
    input  logic [$clog2(FIFO_DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata
);
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    // Single port: either store wdata or register the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                rdata <= r_mem[addr];
            end
        end
    end
endmodule

// File: rtl/spram_fifo_fwft.sv
// FWFT FIFO on a single-port RAM with a 2-entry prefetch buffer, an
// empty-case write bypass and programmable almost-full/empty flags.
module spram_fifo_fwft
    import spram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int CNT_WIDTH  = calc_cnt_width(FIFO_DEPTH),
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    spram_fifo_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]  RAM_CAP = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_LVL  = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_LVL  = CNT_WIDTH'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
    logic [1:0]            r_buf_cnt;
    logic                  r_rvalid;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_af, r_ae;

    ram_op_e               w_ram_op;
    logic                  w_bypass_wr;
    logic                  w_wready, w_wfire, w_rfire;
    logic                  w_ram_empty, w_need_pf, w_bypass_ok;
    logic [2:0]            w_pf_load;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic                  w_in_valid;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic [DATA_WIDTH-1:0] w_buf0_next, w_buf1_next;
    logic [1:0]            w_buf_cnt_next;
    logic [CNT_WIDTH-1:0]  w_count_next;

    assign w_ram_empty = (r_ram_cnt == '0);
    assign w_pf_load   = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
    assign w_need_pf   = !w_ram_empty && (w_pf_load < 3'd2);
    assign w_bypass_ok = w_ram_empty && !r_inflight && (r_buf_cnt < 2'd2);
    assign w_wfire     = bus.wvalid && w_wready;
    assign w_rfire     = r_rvalid && bus.rready;

    // Write acceptance from registered state only (never rready/wvalid).
    always_comb begin
        w_wready = 1'b0;
        if (!rst_n) begin
            w_wready = 1'b0;
        end else if (w_need_pf) begin
            w_wready = w_bypass_ok;
        end else if (w_bypass_ok) begin
            w_wready = 1'b1;
        end else begin
            w_wready = (r_ram_cnt < RAM_CAP);
        end
    end

    // RAM port arbitration: prefetch first, then bypass, then RAM write.
    // A port left idle is reused for a read when the head is popped, so a
    // pure drain keeps one word per cycle.
    always_comb begin
        w_ram_op    = RAM_IDLE;
        w_bypass_wr = 1'b0;
        if (w_need_pf) begin
            w_ram_op = RAM_RD;
        end else if (w_bypass_ok) begin
            w_bypass_wr = w_wfire;
        end else if (w_wfire) begin
            w_ram_op = RAM_WR;
        end else if (!w_ram_empty && (w_pf_load < (3'd2 + {2'b00, w_rfire}))) begin
            w_ram_op = RAM_RD;
        end else begin
            w_ram_op = RAM_IDLE;
        end
    end

    spram_1rw #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_op != RAM_IDLE),
        .we    (w_ram_op == RAM_WR),
        .addr  ((w_ram_op == RAM_WR) ? r_wr_ptr : r_rd_ptr),
        .wdata (bus.wdata),
        .rdata (w_ram_rdata)
    );

    // RAM return and bypass never coincide: bypass needs no read in flight.
    assign w_in_valid = r_inflight || w_bypass_wr;
    assign w_in_data  = r_inflight ? w_ram_rdata : bus.wdata;

    // Prefetch buffer next state: pop at the head, append at the tail.
    always_comb begin
        w_buf0_next    = r_buf0;
        w_buf1_next    = r_buf1;
        w_buf_cnt_next = r_buf_cnt;
        case ({w_rfire, w_in_valid})
            2'b01: begin
                if (r_buf_cnt == 2'd0) begin
                    w_buf0_next = w_in_data;
                end else begin
                    w_buf1_next = w_in_data;
                end
                w_buf_cnt_next = r_buf_cnt + 2'd1;
            end
            2'b10: begin
                w_buf0_next    = r_buf1;
                w_buf_cnt_next = r_buf_cnt - 2'd1;
            end
            2'b11: begin
                if (r_buf_cnt == 2'd1) begin
                    w_buf0_next = w_in_data;
                end else begin
                    w_buf0_next = r_buf1;
                    w_buf1_next = w_in_data;
                end
            end
            default: w_buf_cnt_next = r_buf_cnt;
        endcase
    end

    // Total occupancy follows accepted writes and reads.
    always_comb begin
        case ({w_wfire, w_rfire})
            2'b10:   w_count_next = r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            2'b01:   w_count_next = r_count - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            default: w_count_next = r_count;
        endcase
    end

    // State registers; reset also drops any read data still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_buf_cnt  <= 2'd0;
            r_rvalid   <= 1'b0;
            r_count    <= '0;
            r_af       <= 1'b0;
            r_ae       <= 1'b1;
        end else begin
            if (w_ram_op == RAM_WR) begin
                r_wr_ptr  <= r_wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                r_ram_cnt <= r_ram_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end else if (w_ram_op == RAM_RD) begin
                r_rd_ptr  <= r_rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                r_ram_cnt <= r_ram_cnt - {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            r_inflight <= (w_ram_op == RAM_RD);
            r_buf0     <= w_buf0_next;
            r_buf1     <= w_buf1_next;
            r_buf_cnt  <= w_buf_cnt_next;
            r_rvalid   <= (w_buf_cnt_next != 2'd0);
            r_count    <= w_count_next;
            r_af       <= (w_count_next >= AF_LVL);
            r_ae       <= (w_count_next <= AE_LVL);
        end
    end

    assign bus.wready       = w_wready;
    assign bus.rvalid       = r_rvalid;
    assign bus.rdata        = r_buf0;
    assign bus.count        = r_count;
    assign bus.almost_full  = r_af;
    assign bus.almost_empty = r_ae;
endmodule

// File: tb/tb_spram_fifo_fwft.sv
// Directed and random checks of spram_fifo_fwft at DEPTH = 32.
module tb_spram_fifo_fwft;
    import spram_fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    spram_fifo_if #(.DATA_WIDTH(8), .CNT_WIDTH(6)) bus ();

    spram_fifo_fwft #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.wvalid = 1'b0;
        bus.rready = 1'b0;
        bus.wdata  = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.wvalid = 1'b1;
        bus.rready = 1'b0;
        tick();
        tick();
        total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%b exp=0", bus.wready); end
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
        total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
        total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", bus.almost_empty); end
        bus.wvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (bus.wready !== 1'b1) begin bad++; $display("FAIL post_reset_wready got=%b exp=1", bus.wready); end
    endtask

    task automatic test_bypass();
        do_reset();
        bus.wvalid = 1'b1;
        bus.wdata  = 8'hA5;
        #1;
        total++; if (dut.w_ram_op !== RAM_IDLE) begin bad++; $display("FAIL bypass_ram_op got=%0d exp=%0d", dut.w_ram_op, RAM_IDLE); end
        tick();
        bus.wvalid = 1'b0;
        total++; if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL bypass_rvalid got=%b exp=1", bus.rvalid); end
        total++; if (bus.rdata !== 8'hA5) begin bad++; $display("FAIL bypass_rdata got=%h exp=a5", bus.rdata); end
        total++; if (bus.count !== 6'd1) begin bad++; $display("FAIL bypass_count got=%0d exp=1", bus.count); end
    endtask

    // Fill with 0..40; only 0..33 fit (2 buffer + 32 RAM).
    task automatic test_fill();
        int exp_cnt;
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i <= 40; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = 8'(i);
            total++; if (bus.wready !== (i < 34)) begin bad++; $display("FAIL fill_wready i=%0d got=%b exp=%b", i, bus.wready, (i < 34)); end
            tick();
            exp_cnt = (i < 34) ? i + 1 : 34;
            total++; if (bus.count !== 6'(exp_cnt)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, exp_cnt); end
            total++; if (bus.almost_full !== (exp_cnt >= 30)) begin bad++; $display("FAIL fill_af cnt=%0d got=%b", exp_cnt, bus.almost_full); end
            total++; if (bus.almost_empty !== (exp_cnt <= 1)) begin bad++; $display("FAIL fill_ae cnt=%0d got=%b", exp_cnt, bus.almost_empty); end
        end
        bus.wvalid = 1'b0;
    endtask

    // Drain the full FIFO: 0..33 back to back with no rvalid gap.
    task automatic test_drain();
        bus.wvalid = 1'b0;
        bus.rready = 1'b1;
        for (int k = 0; k < 34; k++) begin
            total++; if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL drain_rvalid k=%0d got=%b exp=1", k, bus.rvalid); end
            total++; if (bus.rdata !== 8'(k)) begin bad++; $display("FAIL drain_rdata k=%0d got=%0d exp=%0d", k, bus.rdata, k); end
            tick();
            total++; if (bus.count !== 6'(33 - k)) begin bad++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, bus.count, 33 - k); end
        end
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL drain_end_rvalid got=%b exp=0", bus.rvalid); end
        total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL drain_end_ae got=%b exp=1", bus.almost_empty); end
        bus.rready = 1'b0;
    endtask

    // 12 words stored (10 in RAM), then both sides stream for 40 cycles.
    task automatic test_contention();
        logic [7:0] q[$];
        logic [7:0] nxt;
        logic       wf, rf, saw_hi, saw_lo;
        int         budget;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = 8'h40 + 8'(i);
            total++; if (bus.wready !== 1'b1) begin bad++; $display("FAIL cont_prefill_wready i=%0d got=%b exp=1", i, bus.wready); end
            q.push_back(bus.wdata);
            tick();
        end
        nxt = 8'h80; saw_hi = 1'b0; saw_lo = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = nxt;
            bus.rready = 1'b1;
            #1;
            wf = bus.wready;
            rf = bus.rvalid;
            if (wf) saw_hi = 1'b1; else saw_lo = 1'b1;
            total++; if (wf && (dut.w_ram_op === RAM_RD)) begin bad++; $display("FAIL cont_wready_on_rd c=%0d got=1 exp=0", c); end
            if (rf) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL cont_underflow c=%0d got=%h exp=none", c, bus.rdata); end
                else begin
                    if (bus.rdata !== q[0]) begin bad++; $display("FAIL cont_rdata c=%0d got=%h exp=%h", c, bus.rdata, q[0]); end
                    void'(q.pop_front());
                end
            end
            if (wf) begin q.push_back(nxt); nxt = nxt + 8'd1; end
            tick();
            total++; if (bus.count !== 6'(q.size())) begin bad++; $display("FAIL cont_count c=%0d got=%0d exp=%0d", c, bus.count, q.size()); end
        end
        total++; if (!(saw_hi && saw_lo)) begin bad++; $display("FAIL cont_wready_toggle got=hi%b/lo%b exp=both", saw_hi, saw_lo); end
        bus.wvalid = 1'b0;
        budget = 0;
        while (q.size() != 0 && budget < 200) begin
            if (bus.rvalid === 1'b1) begin
                total++; if (bus.rdata !== q[0]) begin bad++; $display("FAIL cont_drain_rdata got=%h exp=%h", bus.rdata, q[0]); end
                void'(q.pop_front());
            end
            tick();
            budget++;
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL cont_drain_timeout got=%0d left exp=0", q.size()); end
        total++; if (bus.rvalid !== 1'b0 || bus.count !== 6'd0) begin bad++; $display("FAIL cont_end got=rv%b/cnt%0d exp=rv0/cnt0", bus.rvalid, bus.count); end
        bus.rready = 1'b0;
    endtask

    // Reset while a RAM read is in flight, then a bypass write.
    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = 8'h50 + 8'(i);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.rready = 1'b1;
        tick();
        total++; if (dut.r_inflight !== 1'b1) begin bad++; $display("FAIL rst_mid_inflight got=%b exp=1", dut.r_inflight); end
        bus.rready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL rst_mid_wready got=%b exp=0", bus.wready); end
        tick();
        rst_n = 1'b1;
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL rst_mid_rvalid got=%b exp=0", bus.rvalid); end
        total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", bus.count); end
        #1;
        bus.wvalid = 1'b1;
        bus.wdata  = 8'h3C;
        tick();
        bus.wvalid = 1'b0;
        total++; if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h3C) begin bad++; $display("FAIL rst_mid_bypass got=rv%b/%h exp=rv1/3c", bus.rvalid, bus.rdata); end
        total++; if (bus.count !== 6'd1) begin bad++; $display("FAIL rst_mid_bypass_count got=%0d exp=1", bus.count); end
    endtask

    // 1000 random words with random valid/ready, scoreboard every cycle.
    task automatic test_random();
        logic [7:0] q[$];
        logic       wf, rf;
        int         sent, recv, cyc, wprob, rprob;
        do_reset();
        sent = 0; recv = 0; cyc = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 30000) begin
            wprob = (sent < 500) ? 85 : 45;
            rprob = (sent < 500) ? 35 : 75;
            bus.wvalid = (sent < 1000) && ($urandom_range(0, 99) < wprob);
            bus.wdata  = 8'($urandom);
            bus.rready = (sent >= 1000) || ($urandom_range(0, 99) < rprob);
            #1;
            wf = bus.wvalid && bus.wready;
            rf = bus.rvalid && bus.rready;
            if (q.size() == 34) begin
                total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL rnd_full_wready cyc=%0d got=%b exp=0", cyc, bus.wready); end
            end
            if (rf) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_underflow cyc=%0d got=%h exp=none", cyc, bus.rdata); end
                else begin
                    if (bus.rdata !== q[0]) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.rdata, q[0]); end
                    void'(q.pop_front());
                    recv++;
                end
            end
            if (wf) begin q.push_back(bus.wdata); sent++; end
            tick();
            cyc++;
            total++; if (bus.count !== 6'(q.size()) || bus.count > 6'd34) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.count, q.size()); end
        end
        total++; if (sent != 1000 || recv != 1000) begin bad++; $display("FAIL rnd_complete got=sent%0d/recv%0d exp=1000/1000", sent, recv); end
        bus.wvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n      = 1'b0;
        bus.wvalid = 1'b0;
        bus.rready = 1'b0;
        bus.wdata  = 8'h00;
        test_reset();
        test_bypass();
        test_fill();
        test_drain();
        test_contention();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spram_fifo_fwft.md
Name: spram_fifo_fwft

Overview:
Parametrised successor to the team's single-port-RAM FIFO. It uses valid/ready handshakes on both sides and first-word-fall-through output through a 2-entry prefetch (skid) buffer. A write-to-output bypass serves the empty case, and almost-full/almost-empty flags have programmable thresholds. It sits between streaming producers and consumers where a single-port RAM macro is mandated for area.

Parameters:
DATA_WIDTH, 8, word width
FIFO_DEPTH, 32, RAM words (power of 2, >=4)
ADDR_WIDTH, $clog2(FIFO_DEPTH), RAM address width
OUT_DEPTH, 2, prefetch buffer entries (fixed at 2; the parameter exists for package consistency)
CNT_WIDTH, $clog2(FIFO_DEPTH+OUT_DEPTH+1), occupancy width
AF_THRESH, FIFO_DEPTH-2, almost_full when count >= AF_THRESH
AE_THRESH, 1, almost_empty when count <= AE_THRESH

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
wvalid  in  1  producer has data
wready  out  1  FIFO accepts wdata this cycle
wdata  in  DATA_WIDTH  write data
rvalid  out  1  rdata valid (FWFT head)
rready  in  1  consumer takes head
rdata  out  DATA_WIDTH  head word, registered
count  out  CNT_WIDTH  total occupancy (RAM + in-flight + buffer)
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values:
  - Internal state: wr_ptr = 0, rd_ptr = 0, ram_cnt = 0, inflight = 0, buffer empty.
  - Outputs: rvalid = 0, wready = 0 while rst_n = 0, count = 0, almost_full = 0, almost_empty = 1.
  - RAM contents are not reset.
- Handshake:
  - Write fires on wvalid & wready; read fires on rvalid & rready.
  - wready never depends combinationally on rready or wvalid. It is a function of registered state only.
- RAM: spram_1rw performs one operation per cycle, RAM_IDLE / RAM_RD / RAM_WR. Read data returns 1 cycle after RAM_RD (inflight flag set for that cycle).
- Per-cycle arbitration, evaluated in this order:
  1. need_pf = ram_cnt > 0 & (buf_cnt + inflight) < 2. If need_pf: RAM_RD at rd_ptr, rd_ptr++, ram_cnt--. wready = bypass_ok only.
  2. bypass_ok = ram_cnt == 0 & inflight == 0 & buf_cnt < 2. If bypass_ok: a write fire loads the buffer directly, next cycle; the RAM is not touched.
  3. Otherwise wready = ram_cnt < FIFO_DEPTH, and a write fire does RAM_WR at wr_ptr, wr_ptr++, ram_cnt++.
- Prefetch has priority over RAM writes:
  - With the RAM non-empty and both sides streaming, write throughput drops to 1 per 2 cycles. This is accepted and documented.
  - Reads alone, and bypass flow (RAM empty), sustain 1 word per cycle.
- Buffer fill and flags:
  - Returning RAM data and bypass data are both appended to the buffer tail.
  - rdata is the buffer head; rvalid = buf_cnt > 0.
  - Latency for a write into an empty FIFO: rvalid is asserted the cycle after the write fire.
- Pointers wrap modulo FIFO_DEPTH. ram_cnt has ADDR_WIDTH+1 bits and distinguishes full from empty.
- count:
  - Registered; count_next = count + wfire - rfire.
  - Maximum value is FIFO_DEPTH+2; wready = 0 at that point.
  - Simultaneous wfire & rfire leaves count unchanged.
  - almost_full and almost_empty are decoded from the registered count.
- Ordering: strict FIFO order in all paths. A bypass is only allowed with no RAM data and no in-flight read, so bypass data can never overtake older data.
- Reset mid-operation: all state is cleared on the next edge with rst_n low. Any in-flight RAM read data is discarded.
- Protocol errors: wvalid while wready = 0 is ignored (no overflow). rready while rvalid = 0 has no effect (no underflow).

Decomposition:
- Package spram_fifo_pkg holds:
  - typedef enum logic [1:0] {RAM_IDLE, RAM_RD, RAM_WR} ram_op_e;
  - the OUT_DEPTH localparam;
  - a function computing CNT_WIDTH.
- Sub-module spram_1rw (DATA_WIDTH, FIFO_DEPTH): single-port synchronous RAM with inputs en, we, addr, wdata and output rdata (1-cycle latency). It is a behavioural model, swapped for the macro at synthesis.
- 2-entry buffer and arbitration are inline in spram_fifo_fwft.

Test Plan:
1. Bypass latency. Empty FIFO, write 0xA5 with rready = 0. Expect rvalid = 1, rdata = 0xA5, count = 1 next cycle, and no RAM_WR issued.
2. Fill to capacity. DEPTH = 32, rready = 0, write 0..40. Expect exactly 34 accepted (0..33), then wready = 0. count = 34; almost_full first asserts at count = 30; almost_empty deasserts at count = 2.
3. Drain. From the full state, hold rready = 1 with no writes. Expect 0..33 on 34 consecutive cycles with no rvalid gap, then rvalid = 0, count = 0, almost_empty = 1.
4. Contention. 10 words in RAM, wvalid = 1 and rready = 1 for 40 cycles. Expect wready to toggle on cycles where RAM_RD issues, a scoreboard match with no loss or duplication, and count constant ±1.
5. Reset mid-operation. 12 words stored, rst_n = 0 for 1 cycle during an in-flight read. Expect rvalid = 0, count = 0 at the next edge. The next write of 0x3C appears as the first rdata via bypass.
6. Pointer wrap and random stress. Send 1000 random words with random wvalid/rready at DEPTH = 32. Expect scoreboard order intact, count never above 34, and count equal to the model occupancy every cycle.
